// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states,
// shifter directions and default widths.
package alu_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned SHAMT_W_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SNE  = 4'b1001;
  localparam logic [3:0] ALU_SGE  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_ILL0 = 4'b1100;
  localparam logic [3:0] ALU_ILL1 = 4'b1101;
  localparam logic [3:0] ALU_ILL2 = 4'b1110;
  localparam logic [3:0] ALU_ILL3 = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] SH_LEFT   = 2'd0;
  localparam logic [1:0] SH_RLOG   = 2'd1;
  localparam logic [1:0] SH_RARITH = 2'd2;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return (code == ALU_ILL0) || (code == ALU_ILL1) ||
           (code == ALU_ILL2) || (code == ALU_ILL3);
  endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shifter: holds the working value and remaining count,
// and flags the cycle whose shift produces the final value.
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [XLEN-1:0]    value,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         dir,
  output logic [XLEN-1:0]    next_c,
  output logic               done_c
);

  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         dir_q;

  // Single-bit step in the latched direction.
  always_comb begin
    next_c = work;
    case (dir_q)
      SH_LEFT:   next_c = {work[XLEN-2:0], 1'b0};
      SH_RLOG:   next_c = {1'b0, work[XLEN-1:1]};
      SH_RARITH: next_c = {work[XLEN-1], work[XLEN-1:1]};
      default:   next_c = work;
    endcase
  end

  assign done_c = (count == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      count <= '0;
      dir_q <= SH_LEFT;
    end else if (load) begin
      work  <= value;
      count <= shamt;
      dir_q <= dir;
    end else if (count != '0) begin
      work  <= next_c;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides; single-cycle logic,
// arithmetic and compares, iterative shifts with back-pressure.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_cnt,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  state_t             state;
  logic [SHAMT_W-1:0] shamt_c;
  logic [XLEN-1:0]    alu_res_c;
  logic [XLEN-1:0]    sh_next_c;
  logic [1:0]         sh_dir_c;
  logic               sh_done_c;
  logic               accept_c;
  logic               start_shift_c;

  assign shamt_c       = op_b[SHAMT_W-1:0];
  assign accept_c      = in_valid & in_ready;
  assign start_shift_c = is_shift(alu_cnt) && (shamt_c != '0);

  // Single-cycle datapath; shifts only land here when the amount is zero.
  always_comb begin
    alu_res_c = '0;
    case (alu_cnt)
      ALU_ADD:                   alu_res_c = op_a + op_b;
      ALU_SUB:                   alu_res_c = op_a - op_b;
      ALU_XOR:                   alu_res_c = op_a ^ op_b;
      ALU_OR:                    alu_res_c = op_a | op_b;
      ALU_AND:                   alu_res_c = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res_c = op_a;
      ALU_SLT:                   alu_res_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SNE:                   alu_res_c = XLEN'(op_a != op_b);
      ALU_SGE:                   alu_res_c = XLEN'($signed(op_a) >= $signed(op_b));
      ALU_SLTU:                  alu_res_c = XLEN'(op_a < op_b);
      default:                   alu_res_c = '0;
    endcase
  end

  always_comb begin
    sh_dir_c = SH_LEFT;
    case (alu_cnt)
      ALU_SRL: sh_dir_c = SH_RLOG;
      ALU_SRA: sh_dir_c = SH_RARITH;
      default: sh_dir_c = SH_LEFT;
    endcase
  end

  // Ready is forced low during reset; in HOLD a new request rides the drain.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: in_ready = 1'b1;
        ST_HOLD: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  alu_iter_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept_c & start_shift_c),
    .value  (op_a),
    .shamt  (shamt_c),
    .dir    (sh_dir_c),
    .next_c (sh_next_c),
    .done_c (sh_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
          if (accept_c) begin
            if (start_shift_c) begin
              busy      <= 1'b1;
              out_valid <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              result    <= alu_res_c;
              zero      <= (alu_res_c == '0);
              illegal   <= is_illegal(alu_cnt);
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done_c) begin
            result    <= sh_next_c;
            zero      <= (sh_next_c == '0);
            illegal   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random traffic
// against a plain-arithmetic model with per-cycle output checking.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_cnt   (alu_cnt),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        ill;
    int          vcyc;
    bit          is_sh;
    bit          lit_en;
    logic [31:0] lit_res;
    logic        lit_zf;
    logic        lit_ill;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          acc_count = 0;
  bit          rnd_ready = 0;
  bit          lit_en = 0;
  logic [31:0] lit_res = '0;
  logic        lit_zf = 1'b0;
  logic        lit_ill = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned       sh;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sh = int'(b[4:0]);
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a | b;
      4'd4:    return a & b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return sa >>> sh;
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a != b) ? 32'd1 : 32'd0;
      4'd10:   return (sa >= sb) ? 32'd1 : 32'd0;
      4'd11:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from the accept cycle to the first cycle with out_valid high.
  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd5 && op <= 4'd7 && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle, just after the falling edge.
  always @(negedge clk or negedge rst_n) begin
    logic exp_rdy;
    logic exp_busy;
    exp_t e;
    #1;
    if (!rst_n) begin
      q.delete();
      if (cyc > 0) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
      end
    end else begin
      exp_rdy  = (q.size() == 0) ? 1'b1 : ((cyc >= q[0].vcyc) ? out_ready : 1'b0);
      exp_busy = (q.size() != 0) && q[0].is_sh && (cyc < q[0].vcyc);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (q.size() == 0 || cyc < q[0].vcyc) begin
        chk("out_valid_low", 32'(out_valid), 32'd0);
      end else begin
        chk("out_valid_high", 32'(out_valid), 32'd1);
        chk("result", result, q[0].res);
        chk("zero", 32'(zero), 32'(q[0].zf));
        chk("illegal", 32'(illegal), 32'(q[0].ill));
        if (q[0].lit_en) begin
          chk("lit_result", result, q[0].lit_res);
          chk("lit_zero", 32'(zero), 32'(q[0].lit_zf));
          chk("lit_illegal", 32'(illegal), 32'(q[0].lit_ill));
        end
        if (out_valid && out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        e.res     = model_res(alu_cnt, op_a, op_b);
        e.zf      = (e.res == 32'd0);
        e.ill     = (alu_cnt >= 4'd12);
        e.vcyc    = cyc + model_lat(alu_cnt, op_b);
        e.is_sh   = model_lat(alu_cnt, op_b) > 1;
        e.lit_en  = lit_en;
        e.lit_res = lit_res;
        e.lit_zf  = lit_zf;
        e.lit_ill = lit_ill;
        q.push_back(e);
        acc_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a request and hold it until accepted, then scramble the inputs.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int start;
    int n;
    start    = acc_count;
    n        = 0;
    in_valid = 1'b1;
    alu_cnt  = op;
    op_a     = a;
    op_b     = b;
    while (acc_count == start) begin
      tick();
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout op=%0d: not accepted after %0d cycles", op, n);
        $fatal(1);
      end
    end
    in_valid = 1'b0;
    alu_cnt  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic send_lit(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic z, input logic il);
    lit_en  = 1;
    lit_res = r;
    lit_zf  = z;
    lit_ill = il;
    send(op, a, b);
    lit_en = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0) begin
      tick();
      n++;
      if (n > 300) begin
        $display("FAIL drain_timeout: %0d results still outstanding", q.size());
        $fatal(1);
      end
    end
    tick();
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_cnt   = 4'd0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();

    send_lit(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
    drain();

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send_lit(4'd1, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
    repeat (4) tick();
    out_ready = 1'b1;
    drain();

    send_lit(4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_lit(4'd6, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0);
    send_lit(4'd5, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0);
    send_lit(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    send_lit(4'd11, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    send_lit(4'd10, 32'd5, 32'd5, 32'd1, 1'b0, 1'b0);
    send_lit(4'd9, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    send_lit(4'd14, 32'hDEAD_BEEF, 32'd7, 32'd0, 1'b1, 1'b1);
    send_lit(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    drain();

    // Streaming: four XORs back to back.
    send_lit(4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1'b0);
    send(4'd2, 32'h1111_1111, 32'h2222_2222);
    send(4'd2, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    send(4'd2, 32'h0000_0001, 32'h8000_0000);
    drain();

    // Abort a long shift with reset, then confirm normal operation.
    send(4'd5, 32'h3, 32'd20);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    send_lit(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    drain();

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      send(op, a, b);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
